// File: rtl/duty_setter_if.sv
// rtl/duty_setter_if.sv - pushbutton inputs and duty outputs of the duty setter
interface duty_setter_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [7:0] duty;
    logic       step_pulse;
    logic       at_limit;

    // Board / bench side: drives the raw buttons, observes the duty value
    modport master (
        output btn_up, btn_down, btn_clr,
        input  duty, step_pulse, at_limit
    );

    // Duty setter side
    modport slave (
        input  btn_up, btn_down, btn_clr,
        output duty, step_pulse, at_limit
    );
endinterface

// File: rtl/duty_setter.sv
// rtl/duty_setter.sv - debounced up/down/clear buttons to saturating 8-bit duty value
module duty_setter #(
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int STEP          = 1,
    parameter int INIT_DUTY     = 0
) (
    input  logic         clk,
    input  logic         rst,
    duty_setter_if.slave bus
);

    localparam int BU = 0;
    localparam int BD = 1;
    localparam int BC = 2;

    localparam int DBW  = $clog2(DB_CYCLES);
    localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = $clog2(TMAX);

    localparam logic [DBW-1:0] DB_LAST     = DBW'(DB_CYCLES - 1);
    localparam logic [TW-1:0]  HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]  REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
    localparam logic [7:0]     INIT_VAL    = 8'(INIT_DUTY);
    localparam logic [7:0]     STEP_VAL    = 8'(STEP);
    localparam logic           INIT_LIMIT  = (INIT_DUTY == 0) || (INIT_DUTY == 255);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_HOLD,
        ST_REPEAT
    } state_t;

    logic [2:0]     w_raw;
    logic [2:0]     r_s1;
    logic [2:0]     r_s2;
    logic [2:0]     r_db;
    logic [2:0]     r_db_prev;
    logic [2:0]     r_press;
    logic [DBW-1:0] r_db_cnt [3];

    state_t         r_state;
    state_t         w_state_nxt;
    logic [TW-1:0]  r_timer;
    logic [TW-1:0]  w_timer_nxt;
    logic           r_dir;
    logic           w_dir_nxt;
    logic           w_step;
    logic           w_clr;
    logic           w_held;
    logic           w_other;

    logic [7:0]     r_duty;
    logic           r_step_pulse;
    logic           r_at_limit;
    logic [8:0]     w_sum;
    logic [7:0]     w_duty_up;
    logic [7:0]     w_duty_dn;
    logic [7:0]     w_duty_nxt;

    assign w_raw = {bus.btn_clr, bus.btn_down, bus.btn_up};

    // Two-flop synchronisers, per-button debounce counters and registered rising-edge detect
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1      <= '0;
            r_s2      <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            r_press   <= '0;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_s1      <= w_raw;
            r_s2      <= r_s1;
            r_db_prev <= r_db;
            r_press   <= r_db & ~r_db_prev;
            for (int i = 0; i < 3; i++) begin
                if (r_s2[i] != r_db[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db[i]     <= r_s2[i];
                        r_db_cnt[i] <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // The button that started the current hold, and the opposing one that aborts it
    assign w_held  = r_dir ? r_db[BU] : r_db[BD];
    assign w_other = r_dir ? r_db[BD] : r_db[BU];

    // Next state, hold/repeat timer and step/clear decisions; clear overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_dir_nxt   = r_dir;
        w_step      = 1'b0;
        w_clr       = 1'b0;
        if (r_press[BC]) begin
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_db[BC]) begin
                        if (r_press[BU] && !r_db[BD]) begin
                            w_step      = 1'b1;
                            w_dir_nxt   = 1'b1;
                            w_timer_nxt = '0;
                            w_state_nxt = ST_WAIT_HOLD;
                        end else if (r_press[BD] && !r_db[BU]) begin
                            w_step      = 1'b1;
                            w_dir_nxt   = 1'b0;
                            w_timer_nxt = '0;
                            w_state_nxt = ST_WAIT_HOLD;
                        end
                    end
                end
                ST_WAIT_HOLD: begin
                    if (!w_held || w_other) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == HOLD_LAST) begin
                        w_step      = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = ST_REPEAT;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!w_held || w_other) begin
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == REPEAT_LAST) begin
                        w_step      = 1'b1;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    // Saturating step arithmetic: 9-bit sum for up, compare-before-subtract for down
    always_comb begin
        w_sum      = {1'b0, r_duty} + {1'b0, STEP_VAL};
        w_duty_up  = (w_sum > 9'd255) ? 8'hFF : w_sum[7:0];
        w_duty_dn  = (r_duty < STEP_VAL) ? 8'h00 : (r_duty - STEP_VAL);
        w_duty_nxt = r_duty;
        if (w_clr) begin
            w_duty_nxt = INIT_VAL;
        end else if (w_step) begin
            w_duty_nxt = w_dir_nxt ? w_duty_up : w_duty_dn;
        end
    end

    // State register plus registered duty, strobe and limit flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_dir        <= 1'b0;
            r_duty       <= INIT_VAL;
            r_step_pulse <= 1'b0;
            r_at_limit   <= INIT_LIMIT;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_dir        <= w_dir_nxt;
            r_duty       <= w_duty_nxt;
            r_step_pulse <= w_step | w_clr;
            r_at_limit   <= (w_duty_nxt == 8'h00) || (w_duty_nxt == 8'hFF);
        end
    end

    assign bus.duty       = r_duty;
    assign bus.step_pulse = r_step_pulse;
    assign bus.at_limit   = r_at_limit;

endmodule
